// File: rtl/calc_pkg.sv
// Shared key codes, ALU opcodes, FSM state encoding and operand width for the BCD calculator front end.
package calc_pkg;

    localparam int BCD_W = 9;

    localparam logic [3:0] KEY_ADD    = 4'd10;
    localparam logic [3:0] KEY_SUB    = 4'd11;
    localparam logic [3:0] KEY_EQUALS = 4'd12;
    localparam logic [3:0] KEY_CLEAR  = 4'd13;
    localparam logic [3:0] KEY_NEG    = 4'd14;
    localparam logic [3:0] KEY_NONE   = 4'd15;

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;

    typedef enum logic [1:0] {
        ENTER_OP1,
        ENTER_OP2,
        RESULT
    } state_e;

    function automatic logic is_digit_key(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/calc_entry_fsm_if.sv
// Keypad/ALU/display bundle; master = keypad scanner + ALU side, slave = entry FSM.
interface calc_entry_fsm_if;
    import calc_pkg::*;

    logic             key_strobe;
    logic [3:0]       key_code;
    logic [BCD_W-1:0] alu_result;
    logic             alu_oflag;
    logic [BCD_W-1:0] op1;
    logic [BCD_W-1:0] op2;
    logic [2:0]       opcode;
    logic [BCD_W-1:0] disp_value;
    logic             disp_err;
    logic             result_valid;

    modport master (
        output key_strobe, key_code, alu_result, alu_oflag,
        input  op1, op2, opcode, disp_value, disp_err, result_valid
    );

    modport slave (
        input  key_strobe, key_code, alu_result, alu_oflag,
        output op1, op2, opcode, disp_value, disp_err, result_valid
    );

endinterface

// File: rtl/bcd_operand_reg.sv
// Signed BCD operand register: digit shift-in with saturation, sign toggle, clear and parallel load.
// Updates on the clock edge of the request; no backpressure, requests are one-cycle and never stall.
module bcd_operand_reg
    import calc_pkg::*;
#(
    parameter int DIGITS = 2,
    localparam int W     = 4*DIGITS + 1,
    localparam int CNT_W = $clog2(DIGITS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [W-1:0]     i_load_val,
    input  logic [CNT_W-1:0] i_load_cnt,
    input  logic             i_digit_vld,
    input  logic [3:0]       i_digit,
    input  logic             i_neg,
    output logic [W-1:0]     o_value,
    output logic [CNT_W-1:0] o_cnt
);

    logic [W-1:0]     r_value;
    logic [CNT_W-1:0] r_cnt;
    logic             w_full;
    logic             w_leading_zero;
    logic             w_digit_take;
    logic             w_mag_nz;

    assign w_full         = (r_cnt == CNT_W'(DIGITS));
    assign w_leading_zero = (r_cnt == '0) && (i_digit == 4'd0);
    assign w_digit_take   = i_digit_vld && !w_full && !w_leading_zero;
    // Sign only flips on a non-zero magnitude so negative zero can never be formed.
    assign w_mag_nz       = |r_value[W-2:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= '0;
            r_cnt   <= '0;
        end else if (i_clear) begin
            r_value <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_value <= i_load_val;
            r_cnt   <= i_load_cnt;
        end else if (w_digit_take) begin
            r_value <= {r_value[W-1], r_value[W-6:0], i_digit};
            r_cnt   <= r_cnt + 1'b1;
        end else if (i_neg && w_mag_nz) begin
            r_value[W-1] <= ~r_value[W-1];
        end
    end

    assign o_value = r_value;
    assign o_cnt   = r_cnt;

endmodule

// File: rtl/calc_entry_fsm.sv
// Keypad-to-ALU entry FSM: builds two signed BCD operands, latches opcode, captures ALU result on EQUALS.
// Keys act on their strobe edge, result_valid one cycle later; `CALC_CHAIN_EN lets ADD/SUB chain off a result.
module calc_entry_fsm
    import calc_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic           clk,
    input  logic           rst,
    calc_entry_fsm_if.slave bus
);

    localparam int W     = 4*DIGITS + 1;
    localparam int CNT_W = $clog2(DIGITS + 1);

    state_e           r_state, w_state_nxt;
    logic [2:0]       r_opcode, w_opcode_nxt;
    logic [W-1:0]     r_result, w_result_nxt;
    logic             r_err, w_err_nxt;
    logic             r_result_vld, w_result_vld_nxt;

    logic             w_key_vld;
    logic             w_is_digit;
    logic             w_is_addsub;
    logic [2:0]       w_op_sel;

    logic             w_op1_clr, w_op1_load, w_op1_digit, w_op1_neg;
    logic [W-1:0]     w_op1_load_val;
    logic [CNT_W-1:0] w_op1_load_cnt;
    logic [W-1:0]     w_op1_value;
    logic [CNT_W-1:0] w_op1_cnt_unused;

    logic             w_op2_clr, w_op2_digit, w_op2_neg;
    logic [W-1:0]     w_op2_value;
    logic [CNT_W-1:0] w_op2_cnt;
    logic             w_op2_has_digits;

    assign w_key_vld        = bus.key_strobe && (bus.key_code != KEY_NONE);
    assign w_is_digit       = is_digit_key(bus.key_code);
    assign w_is_addsub      = (bus.key_code == KEY_ADD) || (bus.key_code == KEY_SUB);
    assign w_op_sel         = (bus.key_code == KEY_SUB) ? OP_SUB : OP_ADD;
    assign w_op2_has_digits = (w_op2_cnt != '0);

    bcd_operand_reg #(.DIGITS(DIGITS)) u_op1 (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_op1_clr),
        .i_load      (w_op1_load),
        .i_load_val  (w_op1_load_val),
        .i_load_cnt  (w_op1_load_cnt),
        .i_digit_vld (w_op1_digit),
        .i_digit     (bus.key_code),
        .i_neg       (w_op1_neg),
        .o_value     (w_op1_value),
        .o_cnt       (w_op1_cnt_unused)
    );

    bcd_operand_reg #(.DIGITS(DIGITS)) u_op2 (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_op2_clr),
        .i_load      (1'b0),
        .i_load_val  ('0),
        .i_load_cnt  ('0),
        .i_digit_vld (w_op2_digit),
        .i_digit     (bus.key_code),
        .i_neg       (w_op2_neg),
        .o_value     (w_op2_value),
        .o_cnt       (w_op2_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ENTER_OP1;
            r_opcode     <= OP_ADD;
            r_result     <= '0;
            r_err        <= 1'b0;
            r_result_vld <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_opcode     <= w_opcode_nxt;
            r_result     <= w_result_nxt;
            r_err        <= w_err_nxt;
            r_result_vld <= w_result_vld_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_opcode_nxt     = r_opcode;
        w_result_nxt     = r_result;
        w_err_nxt        = r_err;
        w_result_vld_nxt = 1'b0;
        w_op1_clr        = 1'b0;
        w_op1_load       = 1'b0;
        w_op1_load_val   = '0;
        w_op1_load_cnt   = '0;
        w_op1_digit      = 1'b0;
        w_op1_neg        = 1'b0;
        w_op2_clr        = 1'b0;
        w_op2_digit      = 1'b0;
        w_op2_neg        = 1'b0;

        if (w_key_vld) begin
            if (bus.key_code == KEY_CLEAR) begin
                w_state_nxt  = ENTER_OP1;
                w_opcode_nxt = OP_ADD;
                w_result_nxt = '0;
                w_err_nxt    = 1'b0;
                w_op1_clr    = 1'b1;
                w_op2_clr    = 1'b1;
            end else begin
                case (r_state)
                    ENTER_OP1: begin
                        if (w_is_digit) begin
                            w_op1_digit = 1'b1;
                        end else if (bus.key_code == KEY_NEG) begin
                            w_op1_neg = 1'b1;
                        end else if (w_is_addsub) begin
                            w_opcode_nxt = w_op_sel;
                            w_op2_clr    = 1'b1;
                            w_state_nxt  = ENTER_OP2;
                        end
                    end
                    ENTER_OP2: begin
                        if (w_is_digit) begin
                            w_op2_digit = 1'b1;
                        end else if (bus.key_code == KEY_NEG) begin
                            w_op2_neg = 1'b1;
                        end else if (w_is_addsub && !w_op2_has_digits) begin
                            w_opcode_nxt = w_op_sel;
                        end else if (bus.key_code == KEY_EQUALS && w_op2_has_digits) begin
                            // Operands and opcode are registers, so the ALU output is settled this cycle.
                            w_result_nxt     = bus.alu_result;
                            w_err_nxt        = bus.alu_oflag;
                            w_result_vld_nxt = 1'b1;
                            w_state_nxt      = RESULT;
                        end
                    end
                    RESULT: begin
                        if (w_is_digit) begin
                            w_op1_load     = 1'b1;
                            w_op1_load_val = {{(W-4){1'b0}}, bus.key_code};
                            w_op1_load_cnt = CNT_W'(1);
                            w_err_nxt      = 1'b0;
                            w_state_nxt    = ENTER_OP1;
                        end
`ifdef CALC_CHAIN_EN
                        else if (w_is_addsub && !r_err) begin
                            w_op1_load     = 1'b1;
                            w_op1_load_val = r_result;
                            w_op1_load_cnt = CNT_W'(DIGITS);
                            w_opcode_nxt   = w_op_sel;
                            w_op2_clr      = 1'b1;
                            w_state_nxt    = ENTER_OP2;
                        end
`endif
                    end
                    default: begin
                        w_state_nxt = ENTER_OP1;
                    end
                endcase
            end
        end
    end

    always_comb begin
        bus.disp_value = w_op1_value;
        case (r_state)
            ENTER_OP2: bus.disp_value = w_op2_has_digits ? w_op2_value : w_op1_value;
            RESULT:    bus.disp_value = r_err ? '0 : r_result;
            default:   bus.disp_value = w_op1_value;
        endcase
    end

    assign bus.op1          = w_op1_value;
    assign bus.op2          = w_op2_value;
    assign bus.opcode       = r_opcode;
    assign bus.disp_err     = r_err;
    assign bus.result_valid = r_result_vld;

endmodule
